// File: rtl/intr_ctrl.sv
// Fast interrupt controller: edge-latched requests, fixed-priority arbitration,
// pipeline drain/flush, vector redirect and mret return to the saved PC.
module intr_ctrl #(
  parameter int          NUM_IRQ      = 8,
  parameter int          ID_W         = 3,
  parameter logic [31:0] VEC_BASE     = 32'h0000_0100,
  parameter int          VEC_STRIDE   = 4,
  parameter int          FLUSH_CYCLES = 3
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NUM_IRQ-1:0] irqIn,
  input  logic [NUM_IRQ-1:0] irqEnable,
  input  logic               globalIntEn,
  input  logic               mretD,
  input  logic [31:0]        pcD,
  output logic               flushPipe,
  output logic               stallF,
  output logic               redirectValid,
  output logic [31:0]        redirectPc,
  output logic [31:0]        mepcOut,
  output logic               intrActive,
  output logic [ID_W-1:0]    intrId,
  output logic [NUM_IRQ-1:0] irqAck
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, FLUSH, REDIRECT, HANDLER, RETURN} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [NUM_IRQ-1:0] pending, pending_next, irq_prev, candidate;
  logic [ID_W-1:0]    sel;
  logic               sel_valid;
  logic [31:0]        mepc;

  assign mepcOut = mepc;

  // Downward scan so the lowest candidate index is the last one written.
  always_comb begin
    candidate = pending & irqEnable;
    sel       = '0;
    sel_valid = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (candidate[i]) begin
        sel       = ID_W'(i);
        sel_valid = 1'b1;
      end
    end
  end

  // irqAck is non-zero only during REDIRECT; a same-cycle new edge re-sets the bit.
  assign pending_next = (pending & ~irqAck) | (irqIn & ~irq_prev);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (globalIntEn && sel_valid) begin
          state_next = FLUSH;
          cnt_next   = CNT_W'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (cnt == '0) state_next = REDIRECT;
        else           cnt_next   = cnt - CNT_W'(1);
      end
      REDIRECT: state_next = HANDLER;
      HANDLER:  if (mretD) state_next = RETURN;
      RETURN:   state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with the state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      cnt           <= '0;
      pending       <= '0;
      irq_prev      <= '0;
      mepc          <= '0;
      intrId        <= '0;
      flushPipe     <= 1'b0;
      stallF        <= 1'b0;
      redirectValid <= 1'b0;
      redirectPc    <= '0;
      intrActive    <= 1'b0;
      irqAck        <= '0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      irq_prev <= irqIn;
      pending  <= pending_next;
      if (state == IDLE && state_next == FLUSH) begin
        intrId <= sel;
        mepc   <= pcD;
      end
      flushPipe     <= state_next inside {FLUSH, REDIRECT, RETURN};
      stallF        <= (state_next == FLUSH);
      redirectValid <= state_next inside {REDIRECT, RETURN};
      intrActive    <= state_next inside {HANDLER, RETURN};
      irqAck        <= (state_next == REDIRECT) ? (NUM_IRQ'(1) << intrId) : '0;
      case (state_next)
        REDIRECT: redirectPc <= VEC_BASE + 32'(intrId) * 32'(VEC_STRIDE);
        RETURN:   redirectPc <= mepc;
        default:  redirectPc <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: cycle table for a single entry/exit, plus
// hand-written sequences for reset, priority, masking, mret and mid-flush reset.
module tb_intr_ctrl;

  logic        clk;
  logic        resetn;
  logic [7:0]  irqIn, irqEnable;
  logic        globalIntEn, mretD;
  logic [31:0] pcD;
  logic        flushPipe, stallF, redirectValid, intrActive;
  logic [31:0] redirectPc, mepcOut;
  logic [2:0]  intrId;
  logic [7:0]  irqAck;

  int n_checks = 0;
  int n_fail   = 0;

  intr_ctrl dut (
    .clk(clk), .resetn(resetn), .irqIn(irqIn), .irqEnable(irqEnable),
    .globalIntEn(globalIntEn), .mretD(mretD), .pcD(pcD),
    .flushPipe(flushPipe), .stallF(stallF), .redirectValid(redirectValid),
    .redirectPc(redirectPc), .mepcOut(mepcOut), .intrActive(intrActive),
    .intrId(intrId), .irqAck(irqAck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  irq;
    logic [7:0]  en;
    logic        gie;
    logic        mret;
    logic [31:0] pc;
    logic        flush;
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic        act;
    logic [2:0]  id;
    logic [7:0]  ack;
    logic [31:0] mepc;
  } vec_t;

  vec_t tbl[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_flush"}, 32'(flushPipe), 0);
    check({tag, "_stall"}, 32'(stallF), 0);
    check({tag, "_rv"},    32'(redirectValid), 0);
    check({tag, "_rpc"},   redirectPc, 0);
    check({tag, "_act"},   32'(intrActive), 0);
    check({tag, "_id"},    32'(intrId), 0);
    check({tag, "_ack"},   32'(irqAck), 0);
    check({tag, "_mepc"},  mepcOut, 0);
  endtask

  task automatic wait_rv(input string tag);
    for (int k = 0; k < 30; k++) begin
      tick();
      if (redirectValid) break;
    end
    check({tag, "_rv_timeout"}, 32'(redirectValid), 1);
  endtask

  task automatic do_mret(input string tag, input logic [31:0] exp_pc);
    mretD = 1'b1;
    tick();
    check({tag, "_ret_rv"},    32'(redirectValid), 1);
    check({tag, "_ret_rpc"},   redirectPc, exp_pc);
    check({tag, "_ret_flush"}, 32'(flushPipe), 1);
    check({tag, "_ret_act"},   32'(intrActive), 1);
    mretD = 1'b0;
    tick();
    check({tag, "_post_rv"},  32'(redirectValid), 0);
    check({tag, "_post_act"}, 32'(intrActive), 0);
  endtask

  initial begin
    logic seen;

    resetn      = 1'b0;
    irqIn       = 8'h00;
    irqEnable   = 8'h00;
    globalIntEn = 1'b0;
    mretD       = 1'b0;
    pcD         = 32'h40;

    // Reset: requests toggling while held in reset leave everything at 0
    #1;
    check_zero("rst_hold0");
    for (int k = 0; k < 4; k++) begin
      irqIn = (k % 2 == 0) ? 8'hFF : 8'h00;
      tick();
    end
    check_zero("rst_hold");
    irqIn  = 8'h00;
    tick();
    resetn = 1'b1;
    tick();
    tick();
    check_zero("rst_rel");

    // Single IRQ on line 2, cycle by cycle; enables dropped mid-flush must not abort
    irqEnable   = 8'hFF;
    globalIntEn = 1'b1;
    tick();
    tbl[0] = '{8'h04, 8'hFF, 1'b1, 1'b0, 32'h40, 1'b0, 1'b0, 1'b0, 32'h000, 1'b0, 3'd0, 8'h00, 32'h00};
    tbl[1] = '{8'h04, 8'hFF, 1'b1, 1'b0, 32'h40, 1'b1, 1'b1, 1'b0, 32'h000, 1'b0, 3'd2, 8'h00, 32'h40};
    tbl[2] = '{8'h04, 8'h00, 1'b0, 1'b0, 32'h40, 1'b1, 1'b1, 1'b0, 32'h000, 1'b0, 3'd2, 8'h00, 32'h40};
    tbl[3] = '{8'h04, 8'h00, 1'b0, 1'b0, 32'h40, 1'b1, 1'b1, 1'b0, 32'h000, 1'b0, 3'd2, 8'h00, 32'h40};
    tbl[4] = '{8'h04, 8'hFF, 1'b1, 1'b0, 32'h40, 1'b1, 1'b0, 1'b1, 32'h108, 1'b0, 3'd2, 8'h04, 32'h40};
    tbl[5] = '{8'h04, 8'hFF, 1'b1, 1'b0, 32'h40, 1'b0, 1'b0, 1'b0, 32'h000, 1'b1, 3'd2, 8'h00, 32'h40};
    tbl[6] = '{8'h04, 8'hFF, 1'b1, 1'b1, 32'h40, 1'b1, 1'b0, 1'b1, 32'h040, 1'b1, 3'd2, 8'h00, 32'h40};
    tbl[7] = '{8'h04, 8'hFF, 1'b1, 1'b0, 32'h40, 1'b0, 1'b0, 1'b0, 32'h000, 1'b0, 3'd2, 8'h00, 32'h40};
    for (int i = 0; i < 8; i++) begin
      irqIn       = tbl[i].irq;
      irqEnable   = tbl[i].en;
      globalIntEn = tbl[i].gie;
      mretD       = tbl[i].mret;
      pcD         = tbl[i].pc;
      tick();
      check($sformatf("v%0d_flush", i), 32'(flushPipe), 32'(tbl[i].flush));
      check($sformatf("v%0d_stall", i), 32'(stallF), 32'(tbl[i].stall));
      check($sformatf("v%0d_rv", i), 32'(redirectValid), 32'(tbl[i].rv));
      if (tbl[i].rv) check($sformatf("v%0d_rpc", i), redirectPc, tbl[i].rpc);
      check($sformatf("v%0d_act", i), 32'(intrActive), 32'(tbl[i].act));
      check($sformatf("v%0d_id", i), 32'(intrId), 32'(tbl[i].id));
      check($sformatf("v%0d_ack", i), 32'(irqAck), 32'(tbl[i].ack));
      check($sformatf("v%0d_mepc", i), mepcOut, tbl[i].mepc);
    end
    mretD = 1'b0;

    // Priority: lines 1 and 5 together; 1 first, 5 after return
    irqIn = 8'h00;
    tick();
    irqIn = 8'h22;
    wait_rv("pri1");
    check("pri1_rpc", redirectPc, 32'h104);
    check("pri1_id",  32'(intrId), 1);
    check("pri1_ack", 32'(irqAck), 32'h02);
    tick();
    check("pri1_act", 32'(intrActive), 1);
    pcD = 32'h80;
    do_mret("pri1", 32'h40);
    wait_rv("pri5");
    check("pri5_rpc",  redirectPc, 32'h114);
    check("pri5_id",   32'(intrId), 5);
    check("pri5_ack",  32'(irqAck), 32'h20);
    check("pri5_mepc", mepcOut, 32'h80);
    tick();
    do_mret("pri5", 32'h80);

    // Masking: masked line 3 stays pending and is taken once unmasked
    irqIn     = 8'h00;
    irqEnable = 8'hF7;
    tick();
    irqIn = 8'h08;
    seen  = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (flushPipe) seen = 1'b1;
    end
    check("mask_hold", 32'(seen), 0);
    irqEnable = 8'hFF;
    wait_rv("mask");
    check("mask_rpc", redirectPc, 32'h10C);
    check("mask_ack", 32'(irqAck), 32'h08);
    tick();
    do_mret("mask", 32'h80);

    // mret in IDLE is ignored
    mretD = 1'b1;
    seen  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (redirectValid || flushPipe) seen = 1'b1;
    end
    mretD = 1'b0;
    check("mret_idle", 32'(seen), 0);

    // Async reset in FLUSH cycle 2 clears outputs and pending
    irqIn = 8'h00;
    tick();
    irqIn = 8'h01;
    tick();
    tick();
    tick();
    check("rst_mid_flush", 32'(flushPipe), 1);
    #2;
    resetn = 1'b0;
    #1;
    check_zero("rst_async");
    irqIn = 8'h00;
    tick();
    tick();
    resetn = 1'b1;
    seen   = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (flushPipe || redirectValid) seen = 1'b1;
    end
    check("rst_no_entry", 32'(seen), 0);
    irqIn = 8'h01;
    wait_rv("rst_new");
    check("rst_new_rpc", redirectPc, 32'h100);
    check("rst_new_ack", 32'(irqAck), 32'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
Fast interrupt controller that sequences the five-stage pipeline (IF/ID/EXE/MEM/WB) on interrupt entry and exit.
- Latches edge-triggered requests and arbitrates by fixed priority (lowest index wins).
- Drains and flushes the pipeline, then redirects fetch to a per-source vector.
- Saves the return PC and restores it on mret.
- Sits beside the pipeline stages at top level and drives their flush/stall/redirect inputs.

Parameters:
NUM_IRQ, 8, number of interrupt sources
ID_W, 3, width of interrupt index (clog2 of NUM_IRQ)
VEC_BASE, 32'h0000_0100, vector table base address
VEC_STRIDE, 4, byte spacing between vectors
FLUSH_CYCLES, 3, drain cycles before redirect (must be >= 1)

Ports:
clk  in  1  system clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
irqIn  in  NUM_IRQ  interrupt request lines, synchronous to clk, rising-edge sensitive
irqEnable  in  NUM_IRQ  per-source enable mask
globalIntEn  in  1  global interrupt enable
mretD  in  1  mret decoded in ID stage
pcD  in  32  PC of instruction currently in ID
flushPipe  out  1  invalidate IF/ID stage registers; EXE/MEM/WB keep draining
stallF  out  1  hold PC register
redirectValid  out  1  one-cycle strobe: load redirectPc into PC
redirectPc  out  32  redirect target
mepcOut  out  32  saved return PC
intrActive  out  1  handler running
intrId  out  ID_W  index of the interrupt being served
irqAck  out  NUM_IRQ  one-hot acknowledge pulse

Behaviour:
- Reset (async, resetn=0): state=IDLE; pending, irqPrev, mepc, intrId, FLUSH counter, and all outputs = 0.
- Edge detect:
  - irqPrev <= irqIn every cycle.
  - pending[i] <= 1 when irqIn[i] & ~irqPrev[i].
  - pending[i] is cleared only by the ack of i.
  - If a new edge on i arrives in the same cycle as its ack, set wins.
- Masking: a masked request stays pending and is taken when it is unmasked.
- Candidate set = pending & irqEnable; selection = lowest set index.
- Outputs are registered decodes of state (Moore); redirectPc is valid only while redirectValid=1.
- IDLE:
  - If globalIntEn && |candidate: latch intrId=selection, mepc=pcD, go FLUSH with counter=FLUSH_CYCLES-1.
  - mretD is ignored.
- FLUSH: flushPipe=1, stallF=1. Decrement counter; go REDIRECT when it reaches 0. Lasts exactly FLUSH_CYCLES cycles.
  - Selection is committed: changes to globalIntEn, irqEnable, or irqIn during FLUSH do not abort or change intrId.
- REDIRECT (1 cycle):
  - redirectValid=1, redirectPc = VEC_BASE + intrId*VEC_STRIDE (32-bit, wraps modulo 2^32).
  - irqAck = onehot(intrId); pending[intrId] cleared at the end of the cycle.
  - flushPipe=1, stallF=0.
  - Go HANDLER.
- HANDLER:
  - intrActive=1; no nesting. New edges still latch into pending but are not taken.
  - On mretD: go RETURN.
- RETURN (1 cycle):
  - redirectValid=1, redirectPc=mepc, flushPipe=1, intrActive=1.
  - Go IDLE, with at least one cycle in IDLE before the next entry.
- mepcOut reflects the mepc register at all times; intrId holds its value until the next entry.
- Latency: irqIn rises in cycle t → pending set at t+1 → FLUSH from t+2 through t+1+FLUSH_CYCLES → REDIRECT at t+2+FLUSH_CYCLES.
- Return resumes at the instruction that was in ID at the entry decision; that instruction is flushed and re-executed.

Test Plan:
1. Reset: hold resetn=0, toggle irqIn=0xFF → all outputs 0, no ack; release → IDLE, outputs stay 0.
2. Single IRQ (irqEnable=0xFF, globalIntEn=1, pcD=0x40): irqIn[2] rises at t → flushPipe=1 in t+2..t+4; redirectValid=1, redirectPc=0x108, irqAck=0x04 at t+5; intrActive=1 from t+6; mepcOut=0x40.
3. Priority: irqIn[5] and irqIn[1] rise together → vector 0x104, intrId=1. After mretD: redirectPc=0x40, then irq5 taken with vector 0x114, irqAck=0x20.
4. Masking: irqEnable=0xF7, irqIn[3] rises → no flush for 20 cycles. Set irqEnable=0xFF → entry occurs, vector 0x10C.
5. mret: mretD=1 in IDLE → no redirect. mretD=1 in HANDLER → exactly one cycle of redirectValid with redirectPc=mepc and flushPipe=1, then intrActive=0.
6. Reset mid-operation: drop resetn during FLUSH cycle 2 → outputs 0 immediately (async). Pending is cleared; after release, no entry occurs without a new edge.
